// File: rtl/fnd_scan_ctrl.sv
// 4-digit 7-segment scan controller: binary capture, double-dabble BCD conversion, multiplexed scan with dead time.
// Optional macro LZ_BLANK_EN blanks leading zero digits (ones digit always shown).
module fnd_scan_ctrl #(
  parameter int unsigned SYS_CLK_HZ   = 100_000_000,
  parameter int unsigned SCAN_HZ      = 1000,
  parameter int unsigned BLANK_CYCLES = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] i_value,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [3:0]  fndCom,
  output logic [7:0]  fndFont
);

  localparam int unsigned DIV   = SYS_CLK_HZ / SCAN_HZ;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic [13:0]       bin_q, bin_d;
  logic [15:0]       bcd_q, bcd_d;
  logic [3:0]        iter_q, iter_d;
  logic [15:0]       disp_q, disp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic              start_q;
  logic [3:0]        fnd_com_q, fnd_com_d;
  logic [7:0]        fnd_font_q, fnd_font_d;
  logic              capture;
  logic              tick;
  logic [15:0]       adj;
  logic [3:0]        digit;
  logic              lz;

  function automatic logic [7:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = 8'hFF;
    endcase
  endfunction

  // Conversion FSM; ready lags the return to IDLE by one cycle after DONE.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    disp_d  = disp_q;
    adj     = bcd_q;
    capture = (state_q == IDLE) && ready_q && i_valid;
    ready_d = (state_q == IDLE) && !capture;
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = CONV;
          bin_d   = (i_value > 14'd9999) ? 14'd9999 : i_value;
          bcd_d   = '0;
          iter_d  = '0;
        end
      end
      CONV: begin
        for (int unsigned k = 0; k < 4; k++) begin
          if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
        end
        bcd_d  = {adj[14:0], bin_q[13]};
        bin_d  = {bin_q[12:0], 1'b0};
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd13) state_d = DONE;
      end
      DONE: begin
        disp_d  = bcd_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from next-state so the registered pins line up with the scan state.
  always_comb begin
    tick       = start_q || (cnt_q == CNT_MAX);
    cnt_d      = tick ? '0 : cnt_q + 1'b1;
    idx_d      = start_q ? 2'd0 : (tick ? idx_q + 2'd1 : idx_q);
    digit      = disp_d[{idx_d, 2'b00} +: 4];
`ifdef LZ_BLANK_EN
    case (idx_d)
      2'd3:    lz = (disp_d[15:12] == 4'd0);
      2'd2:    lz = (disp_d[15:8] == 8'd0);
      2'd1:    lz = (disp_d[15:4] == 12'd0);
      default: lz = 1'b0;
    endcase
`else
    lz = 1'b0;
`endif
    fnd_com_d  = '1;
    fnd_font_d = '1;
    if ((32'(cnt_d) >= BLANK_CYCLES) && !lz) begin
      fnd_com_d  = ~(4'b0001 << idx_d);
      fnd_font_d = seg(digit);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      bin_q      <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      disp_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      start_q    <= 1'b1;
      fnd_com_q  <= '1;
      fnd_font_q <= '1;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      iter_q     <= iter_d;
      disp_q     <= disp_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      start_q    <= 1'b0;
      fnd_com_q  <= fnd_com_d;
      fnd_font_q <= fnd_font_d;
    end
  end

  assign o_ready = ready_q;
  assign fndCom  = fnd_com_q;
  assign fndFont = fnd_font_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl: stimulus queues expected frames, a monitor checks scan output every cycle.
module tb_fnd_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [13:0] i_value = '0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [3:0]  fndCom;
  logic [7:0]  fndFont;

  always #5 clk = ~clk;

  fnd_scan_ctrl #(.SYS_CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .i_value(i_value), .i_valid(i_valid),
    .o_ready(o_ready), .fndCom(fndCom), .fndFont(fndFont)
  );

  // fonts packed {digit3,digit2,digit1,digit0}; vis bit per slot that lights up
  typedef struct packed { logic [31:0] fonts; logic [3:0] vis; } frame_t;

`ifdef LZ_BLANK_EN
  localparam frame_t F0000 = {32'hFFFFFFC0, 4'b0001};
  localparam frame_t F0007 = {32'hFFFFFFF8, 4'b0001};
  localparam frame_t F0042 = {32'hFFFF99A4, 4'b0011};
`else
  localparam frame_t F0000 = {32'hC0C0C0C0, 4'b1111};
  localparam frame_t F0007 = {32'hC0C0C0F8, 4'b1111};
  localparam frame_t F0042 = {32'hC0C099A4, 4'b1111};
`endif
  localparam frame_t F1234 = {32'hF9A4B099, 4'b1111};
  localparam frame_t F9999 = {32'h90909090, 4'b1111};
  localparam frame_t F5555 = {32'h92929292, 4'b1111};

  frame_t exp_q[$];
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  bit started = 0;
  bit rst_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Bench-side scan position: cyc 0 is the first cycle after reset release.
  always @(posedge clk) begin
    rst_seen <= !reset;
    if (!reset) started <= 1'b0;
    else if (!started) begin
      started <= 1'b1;
      cyc     <= 0;
    end else cyc <= cyc + 1;
  end

  initial begin : monitor
    frame_t model;
    int low_run;
    int ph, idx;
    logic [3:0] ecom;
    logic [7:0] efont;
    model = F0000;
    low_run = 0;
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        check("rst_com", 32'(fndCom), 32'hF);
        check("rst_font", 32'(fndFont), 32'hFF);
        check("rst_ready", 32'(o_ready), 32'h0);
        low_run = 0;
        exp_q.delete();
        model = F0000;
      end else if (started) begin
        if (cyc == 0) check("ready_after_reset", 32'(o_ready), 32'h1);
        if (!o_ready) low_run++;
        else if (low_run > 0) begin
          check("ready_low_cycles", 32'(low_run), 32'd16);
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL scoreboard_pop: got conversion done expected none pending");
          end else model = exp_q.pop_front();
          low_run = 0;
        end
        if (o_ready || low_run < 16) begin
          ph  = cyc % 10;
          idx = (cyc / 10) % 4;
          if (ph < 2 || !model.vis[idx]) begin
            ecom  = 4'hF;
            efont = 8'hFF;
          end else begin
            ecom  = ~(4'b0001 << idx);
            efont = model.fonts[idx*8 +: 8];
          end
          check($sformatf("scan_cyc%0d", cyc), {20'd0, fndCom, fndFont}, {20'd0, ecom, efont});
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!o_ready && t < 100) begin
      step(1);
      t++;
    end
    if (!o_ready) begin
      checks++;
      $display("FAIL wait_ready: got o_ready=0 expected 1 within 100 cycles");
    end
  endtask

  task automatic send(input logic [13:0] v, input frame_t e, input bit push);
    wait_ready();
    i_value = v;
    i_valid = 1'b1;
    if (push) exp_q.push_back(e);
    step(1);
    i_valid = 1'b0;
  endtask

  initial begin : stim
    bit r;
    int t;
    reset = 1'b0;
    step(3);
    reset = 1'b1;
    step(45);

    send(14'd1234, F1234, 1'b1);
    step(60);
    send(14'd16383, F9999, 1'b1);
    step(60);
    send(14'd7, F0007, 1'b1);
    step(60);

    // 5555 held valid during the 0042 conversion must wait for ready
    send(14'd42, F0042, 1'b1);
    i_value = 14'd5555;
    i_valid = 1'b1;
    exp_q.push_back(F5555);
    t = 0;
    do begin
      @(negedge clk);
      r = o_ready;
      step(1);
      t++;
    end while (!r && t < 100);
    i_valid = 1'b0;
    if (!r) begin
      checks++;
      $display("FAIL hold_capture: got o_ready=0 expected 1 within 100 cycles");
    end
    step(60);

    // reset during conversion of 9876 discards it
    send(14'd9876, F0000, 1'b0);
    step(5);
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(50);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
